// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared types, constants and request checking for the LSU.
//  Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] DMEM_BASE_DEFAULT  = 32'h0010_0000;
    localparam int unsigned DMEM_BYTES_DEFAULT = 4096;
    localparam logic [1:0]  MEM_TYPE_WORD      = 2'b10;

    // Window, alignment and funct3 legality; the window end is exclusive.
    function automatic logic lsu_req_err(input logic        we,
                                         input logic [2:0]  f3,
                                         input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] bytes);
        logic win_ok;
        logic f3_ok;
        logic align_ok;
        win_ok = (addr >= base) && ((addr - base) < bytes);
        if (we)
            f3_ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        else
            f3_ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                    (f3 == F3_LBU) || (f3 == F3_LHU);
        case (f3[1:0])
            2'b01:   align_ok = !addr[0];
            2'b10:   align_ok = (addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        return !(win_ok && f3_ok && align_ok);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_if
//  Purpose  : Core request/response and data-memory bus of the LSU.
//  Revision : 1.0 - initial release
// ============================================================================
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_type;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_read, mem_write, mem_addr, mem_wdata, mem_type
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_read, mem_write, mem_addr, mem_wdata, mem_type
    );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Purpose  : Load lane extraction/extension and store lane merging.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  wire logic [31:0] word_i,
    input  wire logic [31:0] wdata_i,
    input  wire logic [1:0]  offset_i,
    input  wire logic [2:0]  funct3_i,
    output logic      [31:0] load_data_o,
    output logic      [31:0] store_word_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word_i[{offset_i, 3'b000} +: 8];
        half_lane = word_i[{offset_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_LB:   load_data_o = {{24{byte_lane[7]}}, byte_lane};
            F3_LBU:  load_data_o = {24'h0, byte_lane};
            F3_LH:   load_data_o = {{16{half_lane[15]}}, half_lane};
            F3_LHU:  load_data_o = {16'h0, half_lane};
            F3_LW:   load_data_o = word_i;
            default: load_data_o = 32'h0;
        endcase
    end

    always_comb begin
        store_word_o = word_i;
        case (funct3_i)
            F3_SB:   store_word_o[{offset_i, 3'b000} +: 8]     = wdata_i[7:0];
            F3_SH:   store_word_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: store_word_o = wdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : RV32I load/store unit with read-modify-write for SB/SH.
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEFAULT,
    parameter int unsigned DMEM_BYTES = DMEM_BYTES_DEFAULT
) (
    input  wire logic clk,
    input  wire logic rst_n,
    lsu_if.slave      bus
);

    lsu_state_e  state_q;
    logic [1:0]  offset_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign req_err = lsu_req_err(bus.req_we, bus.req_funct3, bus.req_addr,
                                 DMEM_BASE, 32'(DMEM_BYTES));

    lsu_align u_align (
        .word_i      (bus.mem_rdata),
        .wdata_i     (wdata_q),
        .offset_i    (offset_q),
        .funct3_i    (funct3_q),
        .load_data_o (load_data),
        .store_word_o(store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            offset_q     <= 2'b00;
            funct3_q     <= 3'b000;
            we_q         <= 1'b0;
            wdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        offset_q   <= bus.req_addr[1:0];
                        funct3_q   <= bus.req_funct3;
                        we_q       <= bus.req_we;
                        wdata_q    <= bus.req_wdata;
                        mem_addr_q <= {bus.req_addr[31:2], 2'b00};
                        if (req_err) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (bus.req_we && (bus.req_funct3 == F3_SW)) begin
                            // Full-word store needs no read of the old word.
                            state_q     <= WR;
                            mem_write_q <= 1'b1;
                            mem_wdata_q <= bus.req_wdata;
                        end else begin
                            state_q    <= RD;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                RD: begin
                    mem_read_q <= 1'b0;
                    if (we_q) begin
                        state_q     <= WR;
                        mem_write_q <= 1'b1;
                        mem_wdata_q <= store_word;
                    end else begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_data;
                    end
                end
                WR: begin
                    mem_write_q  <= 1'b0;
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_type   = MEM_TYPE_WORD;

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DMEM_BASE, default 32'h0010_0000: byte address of the first data-memory word.
REQ-002 SHALL have parameter DMEM_BYTES, default 4096: size of the legal data-memory window in bytes.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1: core presents a memory request.
REQ-006 SHALL have port req_ready, output, 1: unit can accept a request this cycle.
REQ-007 SHALL have port req_we, input, 1: 1 means store, 0 means load.
REQ-008 SHALL have port req_funct3, input, 3: RV32I funct3 (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-009 SHALL have port req_addr, input, 32: byte address.
REQ-010 SHALL have port req_wdata, input, 32: store data, right-justified.
REQ-011 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 32: load result, extended to 32 bits; 0 for stores and errors.
REQ-013 SHALL have port resp_err, output, 1: misaligned, out-of-window or illegal funct3; valid with resp_valid.
REQ-014 SHALL have port mem_read, output, 1: read strobe to data memory.
REQ-015 SHALL have port mem_write, output, 1: write strobe to data memory.
REQ-016 SHALL have port mem_addr, output, 32: word-aligned byte address, bits [1:0] = 0.
REQ-017 SHALL have port mem_wdata, output, 32: full merged word.
REQ-018 SHALL have port mem_type, output, 2: constant 2'b10 (word access).
REQ-019 SHALL have port mem_rdata, input, 32: data-memory read word, combinationally valid while mem_read is high.

Function
REQ-020 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-021 SHALL accept a request on the rising edge where req_valid && req_ready, registering address, funct3, we and wdata.
REQ-022 SHALL flag an error if addr is outside [DMEM_BASE, DMEM_BASE+DMEM_BYTES), if a halfword has addr[0]=1, if a word has addr[1:0]!=0, or if funct3 is illegal for the direction.
REQ-023 SHALL go IDLE->RESP on an error, with no mem_read or mem_write asserted.
REQ-024 SHALL go IDLE->RD->RESP for a load, and SHALL capture mem_rdata at the end of RD.
REQ-025 SHALL go IDLE->WR->RESP for SW, with mem_wdata = req_wdata.
REQ-026 SHALL go IDLE->RD->WR->RESP for SB and SH (read-modify-write), replacing only the addressed byte or halfword lanes of the captured word.
REQ-027 SHALL assert mem_read only in RD and mem_write only in WR, each for exactly one cycle; mem_addr = {addr[31:2],2'b00} in both states.
REQ-028 SHALL select the load lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-029 SHALL hold resp_valid high for exactly the RESP cycle, then return to IDLE; there is no response backpressure.
REQ-030 SHALL give a latency, counted from the accept edge to resp_valid high, of 1 cycle for errors, 2 cycles for loads and SW, and 3 cycles for SB and SH.
REQ-031 SHALL drive resp_rdata and resp_err to 0 whenever resp_valid is 0.
REQ-032 SHALL ignore req_valid in any state other than IDLE; the earliest next accept is the edge that ends RESP.

Reset
REQ-033 SHALL, on rst_n low at any time, asynchronously enter IDLE and drive resp_valid, resp_err, mem_read and mem_write to 0, with resp_rdata, mem_addr and mem_wdata at 0.
REQ-034 SHALL discard an in-flight request on reset with no response; a reset during WR SHALL deassert mem_write immediately.
REQ-035 SHALL set req_ready = 1 on the first cycle after rst_n deasserts.

Structure
REQ-036 SHALL place the following in shared package lsu_pkg: the FSM state encoding, funct3 constants, DMEM_BASE/DMEM_BYTES defaults and the mem_type word encoding.
REQ-037 SHALL put lane extraction/extension and store merging in the combinational sub-module lsu_align; the FSM and registers SHALL stay in load_store_unit.

Verification
REQ-038 SHALL cover: word 0x00100004 = 32'h16726992; LB at 0x00100004 -> resp_rdata 32'hFFFFFF92; LBU -> 32'h00000092; LB at 0x00100007 -> 32'h00000016; resp_valid 2 cycles after accept.
REQ-039 SHALL cover: LH at 0x00100006 -> 32'h00001672; LH at 0x00100005 -> resp_err=1, no mem_read, resp_valid 1 cycle after accept.
REQ-040 SHALL cover: SB 0x000000AB to 0x00100005 over 32'h16726992 -> one mem_read, then one mem_write of 32'h1672AB92; resp_valid 3 cycles after accept.
REQ-041 SHALL cover: SW 32'hDEADBEEF to 0x00100008 -> one mem_write, no mem_read; then LW -> 32'hDEADBEEF.
REQ-042 SHALL cover: LW at 0x00101000 and funct3=3'b011 -> resp_err=1, mem strobes stay 0.
REQ-043 SHALL cover: rst_n low during the WR cycle of an SH -> mem_write 0 immediately, no resp_valid, req_ready=1 on the first cycle after release.
